// File: rtl/piano_pkg.sv
// Shared piano definitions: key count, note numbers and the key-index to note mapping
// used by the debouncer, segment decoder and tone generator.
package piano_pkg;

  localparam int NUM_KEYS = 7;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_DO   = 3'd1;
  localparam logic [2:0] NOTE_RE   = 3'd2;
  localparam logic [2:0] NOTE_MI   = 3'd3;
  localparam logic [2:0] NOTE_FA   = 3'd4;
  localparam logic [2:0] NOTE_SOL  = 3'd5;
  localparam logic [2:0] NOTE_LA   = 3'd6;
  localparam logic [2:0] NOTE_SI   = 3'd7;

  // Bit 6 is note 1 (DO), bit 0 is note 7 (SI).
  function automatic logic [2:0] key_index_to_note(input logic [2:0] idx);
    return 3'd7 - idx;
  endfunction

endpackage

// File: rtl/key_filter.sv
// Single-key front end: two-flop synchroniser, stability counter and stable register.
// Polarity correction happens outside, between sync_o and k_i.
module key_filter #(
  parameter int D = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw_i,
  output logic sync_o,
  input  logic k_i,
  output logic st_o,
  output logic rise_o
);

  localparam int              CNT_W   = $clog2(D);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(D - 1);

  logic             s1_q;
  logic             s2_q;
  logic             st_q;
  logic             st_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle agreeing with the stable value discards the accumulated count.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (k_i == st_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      st_d  = k_i;
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      st_q  <= 1'b0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      s1_q  <= key_raw_i;
      s2_q  <= s1_q;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign sync_o = s2_q;
  assign st_o   = st_q;
  assign rise_o = st_d & ~st_q;

endmodule

// File: rtl/key_debounce.sv
// Seven-key debouncer: per-key filters, optional active-low correction, press strobe
// and single-key note decode of the debounced vector.
module key_debounce
  import piano_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int KEY_ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] btn,
  output logic                key_valid,
  output logic [2:0]          key_code,
  output logic                key_press
);

  localparam int D = CLK_HZ / 1000 * DEBOUNCE_MS;

  logic [NUM_KEYS-1:0] sync_s;
  logic [NUM_KEYS-1:0] k_s;
  logic [NUM_KEYS-1:0] rise_s;
  logic                key_press_q;
  logic [2:0]          ones_s;
  logic [2:0]          idx_s;

  assign k_s = (KEY_ACTIVE_LOW != 0) ? ~sync_s : sync_s;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_filter #(.D(D)) u_filter (
      .clk       (clk),
      .rst       (rst),
      .key_raw_i (key_raw[g]),
      .sync_o    (sync_s[g]),
      .k_i       (k_s[g]),
      .st_o      (btn[g]),
      .rise_o    (rise_s[g])
    );
  end

  // Strobe lands on the same edge the new btn bit appears; simultaneous rises merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_press_q <= 1'b0;
    end else begin
      key_press_q <= |rise_s;
    end
  end

  assign key_press = key_press_q;

  // Decode is valid only when exactly one key is down.
  always_comb begin
    ones_s    = 3'd0;
    idx_s     = 3'd0;
    key_valid = 1'b0;
    key_code  = NOTE_NONE;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (btn[i]) begin
        ones_s = ones_s + 3'd1;
        idx_s  = 3'(i);
      end else begin
        ones_s = ones_s;
      end
    end
    if (ones_s == 3'd1) begin
      key_valid = 1'b1;
      key_code  = key_index_to_note(idx_s);
    end else begin
      key_valid = 1'b0;
      key_code  = NOTE_NONE;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with D=4; an active-high and an active-low instance share clk/rst.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] key_raw   = 7'h00;
  logic [6:0] key_raw_n = 7'h7F;
  logic [6:0] btn, btn_n;
  logic       key_valid, key_valid_n;
  logic [2:0] key_code, key_code_n;
  logic       key_press, key_press_n;

  int errors = 0;
  int checks = 0;
  int press_cnt = 0;
  int p0;

  always #5 clk = ~clk;

  key_debounce #(.CLK_HZ(4000), .DEBOUNCE_MS(1), .KEY_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw), .btn(btn),
    .key_valid(key_valid), .key_code(key_code), .key_press(key_press)
  );

  key_debounce #(.CLK_HZ(4000), .DEBOUNCE_MS(1), .KEY_ACTIVE_LOW(1)) dut_n (
    .clk(clk), .rst(rst), .key_raw(key_raw_n), .btn(btn_n),
    .key_valid(key_valid_n), .key_code(key_code_n), .key_press(key_press_n)
  );

  // Counts strobe cycles of the active-high instance.
  always @(negedge clk) begin
    if (key_press) press_cnt <= press_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [6:0] bounce [6] = '{7'h40, 7'h00, 7'h40, 7'h40, 7'h00, 7'h40};

  initial begin
    // Reset with all keys held
    key_raw = 7'h7F;
    cyc(3);
    chk("rst_btn", btn, 7'h00);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_press", key_press, 0);
    rst = 1'b0;
    cyc(5);
    chk("post_rst_btn_e4", btn, 7'h00);
    cyc(1);
    chk("post_rst_btn_e5", btn, 7'h7F);
    chk("post_rst_press", key_press, 1);
    chk("post_rst_valid", key_valid, 0);
    cyc(1);
    chk("post_rst_press_1cyc", key_press, 0);
    key_raw = 7'h00;
    cyc(5);
    chk("rel_all_e4", btn, 7'h7F);
    cyc(1);
    chk("rel_all_e5", btn, 7'h00);
    chk("rel_all_nostrobe", key_press, 0);
    cyc(2);

    // Clean press of bit 4
    p0 = press_cnt;
    key_raw = 7'b0010000;
    cyc(5);
    chk("clean_e4", btn, 7'h00);
    cyc(1);
    chk("clean_btn", btn, 7'b0010000);
    chk("clean_valid", key_valid, 1);
    chk("clean_code", key_code, 3);
    chk("clean_press", key_press, 1);
    cyc(1);
    chk("clean_press_off", key_press, 0);
    key_raw = 7'h00;
    cyc(5);
    chk("clean_rel_e4", btn, 7'b0010000);
    cyc(1);
    chk("clean_rel_btn", btn, 7'h00);
    chk("clean_rel_code", key_code, 0);
    cyc(2);
    chk("clean_strobes", press_cnt - p0, 1);

    // Bounce on bit 6, then hold
    p0 = press_cnt;
    foreach (bounce[i]) begin
      key_raw = bounce[i];
      cyc(1);
      chk("bounce_btn", btn, 7'h00);
    end
    cyc(4);
    chk("bounce_hold_e4", btn, 7'h00);
    cyc(1);
    chk("bounce_btn_set", btn, 7'h40);
    chk("bounce_code", key_code, 1);
    // 3-cycle glitch on bit 0
    key_raw = 7'h41;
    cyc(3);
    key_raw = 7'h40;
    cyc(8);
    chk("glitch_btn", btn, 7'h40);
    chk("glitch_strobes", press_cnt - p0, 1);

    // Multi-key: add bit 0
    key_raw = 7'h41;
    cyc(6);
    chk("multi_btn", btn, 7'b1000001);
    chk("multi_valid", key_valid, 0);
    chk("multi_code", key_code, 0);
    chk("multi_press", key_press, 1);
    cyc(2);
    chk("multi_strobes", press_cnt - p0, 2);
    key_raw = 7'h00;
    cyc(8);
    chk("multi_rel", btn, 7'h00);

    // Simultaneous release of bit 4 and press of bit 2
    key_raw = 7'b0010000;
    cyc(8);
    p0 = press_cnt;
    key_raw = 7'b0000100;
    cyc(5);
    chk("simul_e4", btn, 7'b0010000);
    cyc(1);
    chk("simul_btn", btn, 7'b0000100);
    chk("simul_code", key_code, 5);
    chk("simul_press", key_press, 1);
    cyc(3);
    chk("simul_strobes", press_cnt - p0, 1);
    key_raw = 7'h00;
    cyc(8);

    // Reset with counter at 2
    key_raw = 7'b0000001;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_btn", btn, 7'h00);
    cyc(5);
    chk("midrst_e4", btn, 7'h00);
    cyc(1);
    chk("midrst_btn_set", btn, 7'b0000001);
    chk("midrst_code", key_code, 7);
    key_raw = 7'h00;

    // Active-low instance
    chk("al_idle", btn_n, 7'h00);
    key_raw_n = 7'b1111110;
    cyc(5);
    chk("al_e4", btn_n, 7'h00);
    cyc(1);
    chk("al_btn", btn_n, 7'b0000001);
    chk("al_code", key_code_n, 7);
    chk("al_valid", key_valid_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
